// File: rtl/burst_ctl.sv
// burst_ctl -- 68030 synchronous fast-RAM cycle controller with cache-burst support.
//
// The controller accepts a CPU cycle that hits the fast-RAM decode. It waits FIRST_WAIT
// cycles, then terminates it with STERM. A cache burst (CBREQ asserted on a read) produces
// up to four beats, and the address wraps within the 16-byte line.
//
// Ports (all active-low unless noted):
//   CLKCPU  in   CPU clock; every state update happens on its rising edge
//   RESET   in   synchronous reset, sampled on CLKCPU
//   AS20    in   address strobe
//   RW20    in   1 = read, 0 = write (active high)
//   CBREQ   in   cache burst request
//   A[1:0]  in   CPU address bits [3:2]
//   RAM_SEL in   fast-RAM decode hit
//   STERM   out  synchronous termination (one cycle per beat)
//   CBACK   out  cache burst acknowledge
//   RAMOE   out  RAM output enable (reads only)
//   BA[1:0] out  RAM longword address [3:2] of the current beat (active high)
//   BUSY    out  high whenever the controller is not idle (active high)
//
// Build option: define BURST_GAP_EN to insert one idle GAP cycle after each of burst
// beats 0..2. When the macro is undefined, the beats run back-to-back.
//
// All outputs come straight from flops. The next-state logic therefore decides the value
// of each output for the cycle that follows the edge.

module burst_ctl #(
  parameter int unsigned FIRST_WAIT = 1
) (
  input  logic       CLKCPU,
  input  logic       RESET,
  input  logic       AS20,
  input  logic       RW20,
  input  logic       CBREQ,
  input  logic [1:0] A,
  input  logic       RAM_SEL,
  output logic       STERM,
  output logic       CBACK,
  output logic       RAMOE,
  output logic [1:0] BA,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLead = 3'd1,
    StBeat = 3'd2,
`ifdef BURST_GAP_EN
    StGap  = 3'd3,
`endif
    StDone = 3'd4
  } state_e;

  // Load value for the lead-in down-counter. It is unused when FIRST_WAIT is 0.
  localparam logic [1:0] LeadLoad = 2'(FIRST_WAIT - 1);

  state_e     state_q, state_d;
  logic [1:0] wait_q, wait_d;
  logic [1:0] beat_q, beat_d;
  logic       burst_q, burst_d;
  logic       last_q, last_d;
  logic [1:0] ba_q, ba_d;
  logic       sterm_q, sterm_d;
  logic       cback_q, cback_d;
  logic       ramoe_q, ramoe_d;
  logic       busy_q, busy_d;

  // Shared "start a beat on this edge" path, used from IDLE, LEAD, BEAT and GAP.
  logic       enter_beat;
  logic [1:0] beat_idx;
  logic       burst_now;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    beat_d     = beat_q;
    burst_d    = burst_q;
    last_d     = last_q;
    ba_d       = ba_q;
    ramoe_d    = ramoe_q;
    sterm_d    = 1'b1;
    cback_d    = 1'b1;
    enter_beat = 1'b0;
    beat_idx   = beat_q;
    burst_now  = burst_q;

    unique case (state_q)
      StIdle: begin
        if (!AS20 && !RAM_SEL) begin
          ba_d      = A;
          burst_d   = ~CBREQ & RW20;
          burst_now = ~CBREQ & RW20;
          ramoe_d   = ~RW20;
          beat_d    = 2'd0;
          beat_idx  = 2'd0;
          if (FIRST_WAIT == 0) begin
            enter_beat = 1'b1;
          end else begin
            state_d = StLead;
            wait_d  = LeadLoad;
          end
        end
      end

      StLead: begin
        if (AS20) begin
          state_d = StIdle;
          ramoe_d = 1'b1;
        end else if (wait_q == 2'd0) begin
          enter_beat = 1'b1;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end

      StBeat: begin
        if (AS20) begin
          // Abort: BA keeps the address of the interrupted beat.
          state_d = StIdle;
          ramoe_d = 1'b1;
        end else begin
          ba_d = ba_q + 2'd1;
          if (last_q) begin
            state_d = StDone;
            ramoe_d = 1'b1;
          end else begin
            beat_d   = beat_q + 2'd1;
            beat_idx = beat_q + 2'd1;
`ifdef BURST_GAP_EN
            state_d  = StGap;
`else
            enter_beat = 1'b1;
`endif
          end
        end
      end

`ifdef BURST_GAP_EN
      StGap: begin
        if (AS20) begin
          state_d = StIdle;
          ramoe_d = 1'b1;
        end else begin
          enter_beat = 1'b1;
        end
      end
`endif

      StDone: begin
        // Wait for the strobe to go away so that the same bus cycle is not accepted again.
        if (AS20) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        ramoe_d = 1'b1;
      end
    endcase

    // CBREQ is sampled on the edge that opens each beat. Negation there makes this beat
    // the final one, so CBACK is already high while the beat is in progress.
    if (enter_beat) begin
      state_d = StBeat;
      sterm_d = 1'b0;
      last_d  = ~burst_now | CBREQ | (beat_idx == 2'd3);
      cback_d = ~burst_now | CBREQ | (beat_idx == 2'd3);
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLKCPU) begin
    if (!RESET) begin
      state_q <= StIdle;
      wait_q  <= 2'd0;
      beat_q  <= 2'd0;
      burst_q <= 1'b0;
      last_q  <= 1'b0;
      ba_q    <= 2'd0;
      sterm_q <= 1'b1;
      cback_q <= 1'b1;
      ramoe_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      beat_q  <= beat_d;
      burst_q <= burst_d;
      last_q  <= last_d;
      ba_q    <= ba_d;
      sterm_q <= sterm_d;
      cback_q <= cback_d;
      ramoe_q <= ramoe_d;
      busy_q  <= busy_d;
    end
  end

  assign STERM = sterm_q;
  assign CBACK = cback_q;
  assign RAMOE = ramoe_q;
  assign BA    = ba_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_burst_ctl.sv
// Testbench for burst_ctl. Each bus cycle is described by a few parameters: the address,
// the direction, the burst request, the number of beats, and an optional abort or reset
// point. The expected outputs for each clock are derived from the beat positions with
// plain arithmetic.

module tb_burst_ctl;

  localparam int FW = 1;
`ifdef BURST_GAP_EN
  localparam int Stride = 2;
`else
  localparam int Stride = 1;
`endif

  logic       CLKCPU  = 1'b0;
  logic       RESET   = 1'b0;
  logic       AS20    = 1'b1;
  logic       RW20    = 1'b1;
  logic       CBREQ   = 1'b1;
  logic [1:0] A       = 2'd0;
  logic       RAM_SEL = 1'b1;
  logic       STERM;
  logic       CBACK;
  logic       RAMOE;
  logic [1:0] BA;
  logic       BUSY;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLKCPU = ~CLKCPU;

  burst_ctl #(
    .FIRST_WAIT(FW)
  ) dut (
    .CLKCPU (CLKCPU),
    .RESET  (RESET),
    .AS20   (AS20),
    .RW20   (RW20),
    .CBREQ  (CBREQ),
    .A      (A),
    .RAM_SEL(RAM_SEL),
    .STERM  (STERM),
    .CBACK  (CBACK),
    .RAMOE  (RAMOE),
    .BA     (BA),
    .BUSY   (BUSY)
  );

  task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLKCPU);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic s, input logic c, input logic r,
                            input logic b, input bit chk_ba, input logic [1:0] eba);
    check_val({tag, " STERM"}, {3'b0, STERM}, {3'b0, s});
    check_val({tag, " CBACK"}, {3'b0, CBACK}, {3'b0, c});
    check_val({tag, " RAMOE"}, {3'b0, RAMOE}, {3'b0, r});
    check_val({tag, " BUSY"},  {3'b0, BUSY},  {3'b0, b});
    if (chk_ba) check_val({tag, " BA"}, {2'b0, BA}, {2'b0, eba});
  endtask

  // mode: 0 = normal completion, 1 = AS20 abort at edge ev, 2 = RESET at edge ev.
  // If ev_sel is negative, a random edge within the legal range is chosen.
  task automatic run_txn(input logic [1:0] a, input bit rw, input bit cbreq0, input int stop,
                         input int mode, input int ev_sel, input int done_len,
                         input int n_idle);
    bit         burst;
    int         nb, k_last, end_j, ev_j, d, i;
    logic [1:0] model_ba;
    string      tag;
    burst = rw && !cbreq0;
    nb = burst ? stop : 1;
    if (burst && FW == 0 && nb < 2) nb = 2;
    k_last = FW + (nb - 1) * Stride;
    end_j  = k_last + 1 + done_len;
    ev_j   = -1;
    if (mode == 1) begin
      ev_j  = (ev_sel < 0) ? $urandom_range(1, k_last + 1) : ev_sel;
      end_j = ev_j;
    end else if (mode == 2) begin
      ev_j = (ev_sel < 0) ? $urandom_range(1, end_j) : ev_sel;
    end

    for (int n = 0; n < n_idle; n++) begin
      RESET   = 1'b1;
      AS20    = 1'($urandom);
      RAM_SEL = AS20 ? 1'($urandom) : 1'b1;
      A       = 2'($urandom);
      RW20    = 1'($urandom);
      CBREQ   = 1'($urandom);
      step();
      check_outs("idle", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    end

    model_ba = a;
    for (int k = 0; k < 64; k++) begin
      if (k == 0) begin
        RESET = 1'b1; AS20 = 1'b0; RAM_SEL = 1'b0; A = a; RW20 = rw; CBREQ = cbreq0;
      end else begin
        RESET   = !(mode == 2 && k == ev_j);
        AS20    = (k == end_j);
        if (!RESET) AS20 = 1'($urandom);
        RAM_SEL = 1'($urandom);
        A       = 2'($urandom);
        RW20    = 1'($urandom);
        CBREQ   = 1'($urandom);
        if (burst && k >= FW && (k - FW) % Stride == 0) begin
          i = (k - FW) / Stride;
          if (i < nb - 1) CBREQ = 1'b0;
          else if (i == nb - 1 && nb < 4) CBREQ = 1'b1;
        end
      end
      step();
      tag = $sformatf("a=%0d rw=%0d br=%0d nb=%0d m=%0d k=%0d", a, rw, burst, nb, mode, k);
      if (mode == 2 && k == ev_j) begin
        check_outs({tag, " reset"}, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0);
        break;
      end else if (k == end_j) begin
        check_outs({tag, " end"}, 1'b1, 1'b1, 1'b1, 1'b0, (mode == 1), model_ba);
        break;
      end else if (k < FW) begin
        model_ba = a;
        check_outs({tag, " lead"}, 1'b1, 1'b1, !rw, 1'b1, 1'b1, model_ba);
      end else if (k <= k_last) begin
        d = k - FW;
        i = d / Stride;
        if (d % Stride == 0) begin
          model_ba = 2'((int'(a) + i) % 4);
          check_outs({tag, " beat"}, 1'b0, !(burst && i < nb - 1), !rw, 1'b1, 1'b1, model_ba);
        end else begin
          model_ba = 2'((int'(a) + i + 1) % 4);
          check_outs({tag, " gap"}, 1'b1, 1'b1, !rw, 1'b1, 1'b1, model_ba);
        end
      end else begin
        check_outs({tag, " done"}, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
      end
    end
    RESET = 1'b1;
  endtask

  initial begin
    int r;
    RESET = 1'b0;
    AS20  = 1'b0;
    RAM_SEL = 1'b0;
    step();
    check_outs("reset0", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0);
    step();
    check_outs("reset1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0);
    AS20  = 1'b1;
    RESET = 1'b1;
    step();
    check_outs("post reset", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0);

    // Directed cycles.
    run_txn(2'd2, 1'b1, 1'b1, 1, 0, 0, 2, 1);                   // single read
    run_txn(2'd3, 1'b1, 1'b0, 4, 0, 0, 1, 0);                   // wrapping burst
    run_txn(2'd0, 1'b1, 1'b0, 2, 0, 0, 1, 1);                   // early stop after beat 1
    run_txn(2'd1, 1'b1, 1'b0, 4, 1, 1, 0, 1);                   // abort in lead
    run_txn(2'd1, 1'b1, 1'b0, 4, 2, FW + 2 * Stride + 1, 0, 1); // reset after beat 2
    run_txn(2'd1, 1'b0, 1'b0, 4, 0, 0, 1, 0);                   // write, no burst
    run_txn(2'd0, 1'b1, 1'b0, 3, 1, FW + 2 * Stride, 0, 1);     // abort with CBREQ negation

    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 9);
      run_txn(2'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
              $urandom_range(1, 4), (r < 6) ? 0 : ((r < 8) ? 1 : 2), -1,
              $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/burst_ctl.md
BURST_CTL -- requirements
Module: burst_ctl

Interface
REQ-001 SHALL have parameter FIRST_WAIT, default 1, meaning the number of CLKCPU cycles from cycle accept to the first beat (legal 0..3).
REQ-002 SHALL have port CLKCPU, input, 1 bit: the only clock; all state updates on the rising edge.
REQ-003 SHALL have port RESET, input, 1 bit: synchronous, active-low reset, sampled on the CLKCPU rising edge.
REQ-004 SHALL have port AS20, input, 1 bit: 68030 address strobe, active low.
REQ-005 SHALL have port RW20, input, 1 bit: 1 = read, 0 = write.
REQ-006 SHALL have port CBREQ, input, 1 bit: cache burst request, active low.
REQ-007 SHALL have port A, input, 2 bits: CPU address bits [3:2] of the cycle.
REQ-008 SHALL have port RAM_SEL, input, 1 bit: fast-RAM decode hit, active low.
REQ-009 SHALL have port STERM, output, 1 bit: synchronous termination, active low.
REQ-010 SHALL have port CBACK, output, 1 bit: cache burst acknowledge, active low.
REQ-011 SHALL have port RAMOE, output, 1 bit: RAM output enable, active low.
REQ-012 SHALL have port BA, output, 2 bits: RAM longword address bits [3:2] for the current beat.
REQ-013 SHALL have port BUSY, output, 1 bit: high while not in IDLE.

Function
REQ-014 SHALL implement the states IDLE, LEAD, BEAT, GAP and DONE.
REQ-015 In IDLE, SHALL accept a cycle when AS20=0 and RAM_SEL=0 are sampled together.
- On accept, latch BA<=A and BURST<=(~CBREQ & RW20).
- Go to LEAD if FIRST_WAIT>0, otherwise go to BEAT.
REQ-016 LEAD SHALL last exactly FIRST_WAIT cycles, counted by a 2-bit down-counter, then go to BEAT.
REQ-017 RAMOE SHALL be 0 from the cycle after accept until leaving BEAT/GAP on reads; it SHALL remain 1 on writes.
REQ-018 BEAT SHALL last one cycle with STERM=0.
- BA SHALL hold the beat address during BEAT.
- BA SHALL increment modulo 4 (3 wraps to 0) on exit from BEAT.
REQ-019 A non-burst cycle SHALL produce exactly one beat and then go to DONE.
REQ-020 A burst cycle SHALL produce 4 beats, tracked by a beat counter 0..3.
REQ-021 CBACK SHALL be 0 during beats 0..2 of a burst and 1 during beat 3; CBACK SHALL be 1 in every non-burst beat.
REQ-022 CBREQ SHALL be sampled in each burst BEAT.
- If CBREQ=1, the current beat is the last one: CBACK=1 in that beat, next state DONE.
REQ-023 DONE SHALL hold all outputs inactive and return to IDLE only when AS20=1 is sampled, so no re-accept occurs within the same bus cycle.
REQ-024 AS20=1 sampled in LEAD, BEAT or GAP SHALL abort.
- Next state IDLE.
- STERM, CBACK and RAMOE SHALL be 1 from the following cycle.
- BA SHALL hold its value.
REQ-025 When AS20 rises and CBREQ negates on the same edge, the AS20 abort SHALL take priority.
REQ-026 STERM and CBACK SHALL never be 0 outside BEAT.
REQ-027 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-028 When RESET=0 on a rising edge, SHALL set: state IDLE, STERM=1, CBACK=1, RAMOE=1, BA=0, BUSY=0, all counters 0.
REQ-029 Reset asserted mid-burst SHALL take priority over every transition, including an abort.
REQ-030 After RESET returns to 1, SHALL accept a new cycle no earlier than the following edge.

Configuration
REQ-031 The macro BURST_GAP_EN SHALL control the GAP state.
REQ-032 With BURST_GAP_EN defined:
- A burst SHALL insert one GAP cycle after each of beats 0..2.
- In GAP: STERM=1, CBACK=1, RAMOE held 0.
- A full burst SHALL be 7 cycles from the first beat to the last.
REQ-033 Without BURST_GAP_EN:
- GAP SHALL be unreachable and not synthesised.
- Beats SHALL be back-to-back, so a full burst spans 4 cycles.

Verification
REQ-034 Single read: FIRST_WAIT=1, A=2, CBREQ=1, RW20=1, RAM_SEL=0 -> one LEAD cycle, one STERM=0 cycle with BA=2 and CBACK=1, then DONE until AS20=1.
REQ-035 Wrapping burst, no macro: A=3, CBREQ=0, RW20=1 -> STERM=0 on 4 consecutive cycles with BA=3,0,1,2 and CBACK=0,0,0,1.
REQ-036 Early burst stop: CBREQ negated during beat 1 -> beat 1 has CBACK=1 and is the last STERM; DONE follows; exactly 2 beats occur.
REQ-037 Abort and reset: AS20=1 during LEAD -> no STERM, idle next cycle. RESET=0 during beat 2 -> all outputs inactive and BA=0 next cycle.
REQ-038 Gap mode, BURST_GAP_EN defined, A=0 -> STERM pattern 0,1,0,1,0,1,0; BA=0,1,2,3 on the beats; RAMOE=0 throughout.
REQ-039 Write with CBREQ=0, RW20=0 -> single beat, CBACK=1, RAMOE=1.
